rdma_wr_qp_scheduler: RTL and testbench
=======================================

Name: rdma_wr_qp_scheduler

Overview:
- Sequences RDMA WRITE traffic for one track at a time.
- On each RDMA_write_en pulse it picks the target host QP (round-robin across IMCs, track_num_per_IMC tracks per IMC) and splits the track into WQE post requests of at most MAX_WQE_BYTES.
- Caps the number of uncompleted WQEs at MAX_OUTSTANDING and pulses RDMA_track_done once every WQE of the track has completed.
- Sits between the RDMA top-level FSM (RDMA_write_en / RDMA_track_done) and the ERNIC WQE-post / completion logic.

Parameters:
- QP_NUM, 8, total QPs including QP1; host data QPs are 2..QP_NUM.
- QPN_BASE, 2, QPN of the first host data QP.
- MAX_WQE_BYTES, 65536, maximum bytes per WQE; must be a power of two.
- MAX_OUTSTANDING, 4, maximum posted-but-uncompleted WQEs; range 1..15.

Ports:
- core_clk  in  1  clock.
- core_areset  in  1  reset; asynchronous, active-high.
- RDMA_write_en  in  1  one-cycle pulse requesting the next track.
- IMC_NUM  in  4  number of active IMCs/QPs; 0 is treated as 1.
- track_num_per_IMC  in  4  tracks sent per QP before advancing; 0 is treated as 1.
- track_bytes  in  32  bytes per track.
- host_MR_valid  in  QP_NUM-1  bit i set means the MR for QPN QPN_BASE+i is registered.
- wqe_req_valid  out  1  WQE post request valid.
- wqe_req_ready  in  1  WQE post request accepted.
- wqe_qpn  out  4  target QPN.
- wqe_offset  out  32  byte offset into the host MR.
- wqe_len  out  32  WQE length in bytes.
- wqe_last  out  1  this is the final WQE of the track.
- cq_done_valid  in  1  one-cycle completion pulse, one per WQE.
- cq_error  in  1  completion carried error status; qualified by cq_done_valid.
- RDMA_track_done  out  1  one-cycle pulse when the track is fully complete.
- sched_busy  out  1  high in every state except IDLE and ERROR.
- sched_err  out  1  sticky error flag.
- cur_wr_QPN  out  4  QPN the next or current track targets.
- outstanding_cnt  out  4  current count of uncompleted WQEs.

Behaviour:
- Reset values: all outputs 0 except cur_wr_QPN = QPN_BASE. All internal counters 0. State = IDLE.
- Internal state:
  - qp_idx: 0..IMC_NUM-1.
  - trk_idx: 0..track_num_per_IMC-1.
  - rem: remaining track bytes, 32 bits.
  - chunk_off: byte offset within the track, 32 bits.
- Reported signals:
  - cur_wr_QPN = QPN_BASE + qp_idx.
  - wqe_offset = trk_idx*track_bytes + chunk_off, computed modulo 2^32 with no saturation.
- States: IDLE, CHECK, ISSUE, WAIT_CPL, DONE, ERROR.
- IDLE:
  - On RDMA_write_en, latch track_bytes into rem, clear chunk_off, go to CHECK.
  - RDMA_write_en arriving in any other state is ignored.
- CHECK (1 cycle):
  - If host_MR_valid[qp_idx]==0, go to ERROR.
  - Else if rem==0, go to DONE; no WQE is issued.
  - Else go to ISSUE.
- ISSUE:
  - wqe_req_valid is asserted only while outstanding_cnt < MAX_OUTSTANDING. When the cap is reached it deasserts and is held low until a completion frees a slot.
  - wqe_len = min(rem, MAX_WQE_BYTES). wqe_last = (rem <= MAX_WQE_BYTES).
  - Outputs are registered and stay stable while valid is high and ready is low.
  - On handshake: rem -= wqe_len, chunk_off += wqe_len, outstanding_cnt++.
  - If wqe_last was set at the handshake, go to WAIT_CPL; otherwise the next WQE is presented no earlier than the following cycle.
- WAIT_CPL: when outstanding_cnt==0, go to DONE.
- DONE (1 cycle):
  - Pulse RDMA_track_done.
  - If trk_idx == track_num_per_IMC-1: set trk_idx = 0, and set qp_idx = 0 if qp_idx >= IMC_NUM-1, else qp_idx+1.
  - Otherwise trk_idx++.
  - Go to IDLE.
- outstanding_cnt update:
  - Handshake and cq_done_valid in the same cycle: count unchanged.
  - cq_done_valid alone: count decrements.
- Error conditions: any of the following sets sched_err and moves to ERROR.
  - cq_done_valid while outstanding_cnt==0 with no simultaneous handshake (underflow).
  - cq_done_valid together with cq_error.
- ERROR:
  - Terminal until core_areset.
  - wqe_req_valid = 0, no RDMA_track_done, completions ignored.
- Reset mid-operation: everything returns to reset values immediately, including counters, qp_idx and any partially issued track.
- IMC_NUM and track_num_per_IMC are used live in DONE. Changing them mid-stream takes effect at the next track boundary.

Test Plan:
- IMC_NUM=2, track_num_per_IMC=1, track_bytes=0x1000, all MR valid, ready tied 1, each completion returned 5 cycles after its WQE:
  - two tracks produce one WQE each: (qpn 2, off 0, len 0x1000, last 1), then (qpn 3, off 0, len 0x1000, last 1).
  - third track wraps back to qpn 2.
  - RDMA_track_done pulses once per track.
- track_bytes=0x28000, MAX_WQE_BYTES=0x10000:
  - three WQEs: len 0x10000 / 0x10000 / 0x8000 at offsets 0 / 0x10000 / 0x20000.
  - wqe_last set only on the third.
- track_num_per_IMC=3, track_bytes=0x1000, IMC_NUM=1: successive tracks use offsets 0, 0x1000, 0x2000, then wrap to 0; qpn stays 2.
- MAX_OUTSTANDING=4, track of 6 WQEs, completions withheld:
  - exactly 4 handshakes, then wqe_req_valid stays 0.
  - one cq_done_valid lets exactly one more WQE through.
  - a completion in the same cycle as a handshake leaves outstanding_cnt unchanged.
- host_MR_valid=0 for QPN 2, RDMA_write_en -> ERROR:
  - sched_err=1, no WQE and no done pulse.
  - core_areset clears sched_err and returns cur_wr_QPN to 2.
- Error injection:
  - cq_done_valid with cq_error=1 mid-track -> ERROR with sched_err=1.
  - stray cq_done_valid while idle with count 0 -> sched_err=1.
  - track_bytes=0 -> RDMA_track_done 2 cycles after RDMA_write_en, no WQE issued.

Source files
------------

// File: rtl/rdma_wr_qp_scheduler.sv
// ============================================================================
// Module      : rdma_wr_qp_scheduler
// Description : Per-track RDMA WRITE sequencer: picks the host QP round-robin,
//               splits the track into WQE posts and tracks their completions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rdma_wr_qp_scheduler #(
  parameter int QP_NUM          = 8,
  parameter int QPN_BASE        = 2,
  parameter int MAX_WQE_BYTES   = 65536,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              core_clk,
  input  logic              core_areset,
  input  logic              RDMA_write_en,
  input  logic [3:0]        IMC_NUM,
  input  logic [3:0]        track_num_per_IMC,
  input  logic [31:0]       track_bytes,
  input  logic [QP_NUM-2:0] host_MR_valid,
  output logic              wqe_req_valid,
  input  logic              wqe_req_ready,
  output logic [3:0]        wqe_qpn,
  output logic [31:0]       wqe_offset,
  output logic [31:0]       wqe_len,
  output logic              wqe_last,
  input  logic              cq_done_valid,
  input  logic              cq_error,
  output logic              RDMA_track_done,
  output logic              sched_busy,
  output logic              sched_err,
  output logic [3:0]        cur_wr_QPN,
  output logic [3:0]        outstanding_cnt
);

  localparam logic [31:0] c_MAX_WQE = 32'(MAX_WQE_BYTES);
  localparam logic [3:0]  c_MAX_OS  = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_CPL = 3'd3,
    S_DONE     = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_qp_idx;
  logic [3:0]  r_trk_idx;
  logic [31:0] r_rem;
  logic [31:0] r_chunk_off;
  logic [31:0] r_trk_base;
  logic [3:0]  r_cnt;

  logic        w_hs;
  logic        w_cq;
  logic        w_err;
  logic [3:0]  w_imc;
  logic [3:0]  w_tn;
  logic [15:0] w_mr_ext;
  logic        w_mr_ok;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_off_nxt;
  logic [31:0] w_len_nxt;
  logic [3:0]  w_cnt_nxt;

  assign w_hs      = wqe_req_valid & wqe_req_ready;
  assign w_cq      = cq_done_valid & (r_state != S_ERROR);
  // A completion is fatal if it carries error status or nothing is outstanding.
  assign w_err     = w_cq & (cq_error | ((r_cnt == 4'd0) & ~w_hs));
  assign w_imc     = (IMC_NUM == 4'd0) ? 4'd1 : IMC_NUM;
  assign w_tn      = (track_num_per_IMC == 4'd0) ? 4'd1 : track_num_per_IMC;
  assign w_mr_ext  = 16'(host_MR_valid);
  assign w_mr_ok   = w_mr_ext[r_qp_idx];
  assign w_rem_nxt = w_hs ? (r_rem - wqe_len) : r_rem;
  assign w_off_nxt = w_hs ? (r_chunk_off + wqe_len) : r_chunk_off;
  assign w_len_nxt = (w_rem_nxt > c_MAX_WQE) ? c_MAX_WQE : w_rem_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!w_err) begin
      if (w_hs && !w_cq)
        w_cnt_nxt = r_cnt + 4'd1;
      else if (!w_hs && w_cq)
        w_cnt_nxt = r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (RDMA_write_en) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (!w_mr_ok)
          w_state_nxt = S_ERROR;
        else if (r_rem == 32'd0)
          w_state_nxt = S_DONE;
        else
          w_state_nxt = S_ISSUE;
      end
      S_ISSUE:    if (w_hs && wqe_last) w_state_nxt = S_WAIT_CPL;
      S_WAIT_CPL: if (r_cnt == 4'd0) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      S_ERROR:    w_state_nxt = S_ERROR;
      default:    w_state_nxt = S_IDLE;
    endcase
    if (w_err)
      w_state_nxt = S_ERROR;
  end

  always_ff @(posedge core_clk or posedge core_areset) begin
    if (core_areset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge core_clk or posedge core_areset) begin
    if (core_areset) begin
      r_qp_idx      <= 4'd0;
      r_trk_idx     <= 4'd0;
      r_rem         <= 32'd0;
      r_chunk_off   <= 32'd0;
      r_trk_base    <= 32'd0;
      r_cnt         <= 4'd0;
      wqe_req_valid <= 1'b0;
      wqe_qpn       <= 4'd0;
      wqe_offset    <= 32'd0;
      wqe_len       <= 32'd0;
      wqe_last      <= 1'b0;
      sched_err     <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;

      if (r_state == S_IDLE && RDMA_write_en) begin
        r_rem       <= track_bytes;
        r_chunk_off <= 32'd0;
        r_trk_base  <= {28'd0, r_trk_idx} * track_bytes;
      end else if (w_hs) begin
        r_rem       <= w_rem_nxt;
        r_chunk_off <= w_off_nxt;
      end

      // Payload only moves when no request is stalled on the bus.
      if (w_state_nxt == S_ISSUE && !(wqe_req_valid && !wqe_req_ready)) begin
        wqe_qpn    <= cur_wr_QPN;
        wqe_offset <= r_trk_base + w_off_nxt;
        wqe_len    <= w_len_nxt;
        wqe_last   <= (w_rem_nxt <= c_MAX_WQE);
      end
      wqe_req_valid <= (w_state_nxt == S_ISSUE) && (w_cnt_nxt < c_MAX_OS);

      if (w_state_nxt == S_ERROR)
        sched_err <= 1'b1;

      if (r_state == S_DONE) begin
        if (r_trk_idx >= w_tn - 4'd1) begin
          r_trk_idx <= 4'd0;
          r_qp_idx  <= (r_qp_idx >= w_imc - 4'd1) ? 4'd0 : r_qp_idx + 4'd1;
        end else begin
          r_trk_idx <= r_trk_idx + 4'd1;
        end
      end
    end
  end

  assign cur_wr_QPN      = 4'(QPN_BASE) + r_qp_idx;
  assign outstanding_cnt = r_cnt;
  assign RDMA_track_done = (r_state == S_DONE);
  assign sched_busy      = (r_state != S_IDLE) && (r_state != S_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_rdma_wr_qp_scheduler.sv
// ============================================================================
// Module      : tb_rdma_wr_qp_scheduler
// Description : Directed self-checking bench for rdma_wr_qp_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rdma_wr_qp_scheduler;

  logic        core_clk = 1'b0;
  logic        core_areset;
  logic        RDMA_write_en;
  logic [3:0]  IMC_NUM;
  logic [3:0]  track_num_per_IMC;
  logic [31:0] track_bytes;
  logic [6:0]  host_MR_valid;
  logic        wqe_req_valid;
  logic        wqe_req_ready;
  logic [3:0]  wqe_qpn;
  logic [31:0] wqe_offset;
  logic [31:0] wqe_len;
  logic        wqe_last;
  logic        cq_done_valid;
  logic        cq_error;
  logic        RDMA_track_done;
  logic        sched_busy;
  logic        sched_err;
  logic [3:0]  cur_wr_QPN;
  logic [3:0]  outstanding_cnt;

  rdma_wr_qp_scheduler dut (
    .core_clk          (core_clk),
    .core_areset       (core_areset),
    .RDMA_write_en     (RDMA_write_en),
    .IMC_NUM           (IMC_NUM),
    .track_num_per_IMC (track_num_per_IMC),
    .track_bytes       (track_bytes),
    .host_MR_valid     (host_MR_valid),
    .wqe_req_valid     (wqe_req_valid),
    .wqe_req_ready     (wqe_req_ready),
    .wqe_qpn           (wqe_qpn),
    .wqe_offset        (wqe_offset),
    .wqe_len           (wqe_len),
    .wqe_last          (wqe_last),
    .cq_done_valid     (cq_done_valid),
    .cq_error          (cq_error),
    .RDMA_track_done   (RDMA_track_done),
    .sched_busy        (sched_busy),
    .sched_err         (sched_err),
    .cur_wr_QPN        (cur_wr_QPN),
    .outstanding_cnt   (outstanding_cnt)
  );

  always #5 core_clk = ~core_clk;

  typedef struct packed {
    logic [3:0]  qpn;
    logic [31:0] off;
    logic [31:0] len;
    logic        last;
  } wqe_t;

  wqe_t wq[$];
  int   n_done = 0;
  int   n_chk  = 0;
  int   n_err  = 0;

  // Accepted WQEs and done pulses, as seen at the active edge.
  always @(posedge core_clk) begin
    if (wqe_req_valid && wqe_req_ready)
      wq.push_back('{qpn: wqe_qpn, off: wqe_offset, len: wqe_len, last: wqe_last});
    if (RDMA_track_done)
      n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge core_clk);
  endtask

  task automatic chk_wqe(input string tag, input int idx, input logic [3:0] qpn,
                         input logic [31:0] off, input logic [31:0] len, input logic last);
    wqe_t w;
    w = (idx < wq.size()) ? wq[idx] : '0;
    chk({tag, " present"}, 32'(idx < wq.size()), 32'd1);
    chk({tag, " qpn"}, {28'd0, w.qpn}, {28'd0, qpn});
    chk({tag, " off"}, w.off, off);
    chk({tag, " len"}, w.len, len);
    chk({tag, " last"}, {31'd0, w.last}, {31'd0, last});
  endtask

  // Requests one track and returns each completion 5 cycles after its WQE.
  task automatic run_track(input string tag);
    int d0;
    int seen;
    int due[$];
    d0   = n_done;
    seen = wq.size();
    RDMA_write_en = 1'b1;
    step(1);
    RDMA_write_en = 1'b0;
    for (int t = 0; t < 80 && n_done == d0; t++) begin
      step(1);
      cq_done_valid = 1'b0;
      while (seen < wq.size()) begin
        due.push_back(t + 5);
        seen++;
      end
      if (due.size() > 0 && due[0] <= t) begin
        cq_done_valid = 1'b1;
        void'(due.pop_front());
      end
    end
    cq_done_valid = 1'b0;
    chk({tag, " done pulses"}, 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int b;
    int d0;
    core_areset       = 1'b1;
    RDMA_write_en     = 1'b0;
    IMC_NUM           = 4'd2;
    track_num_per_IMC = 4'd1;
    track_bytes       = 32'h1000;
    host_MR_valid     = 7'h7F;
    wqe_req_ready     = 1'b1;
    cq_done_valid     = 1'b0;
    cq_error          = 1'b0;
    step(3);

    chk("rst valid", {31'd0, wqe_req_valid}, 32'd0);
    chk("rst done", {31'd0, RDMA_track_done}, 32'd0);
    chk("rst busy", {31'd0, sched_busy}, 32'd0);
    chk("rst err", {31'd0, sched_err}, 32'd0);
    chk("rst qpn", {28'd0, cur_wr_QPN}, 32'd2);
    chk("rst cnt", {28'd0, outstanding_cnt}, 32'd0);
    chk("rst wqe_len", wqe_len, 32'd0);
    chk("rst wqe_off", wqe_offset, 32'd0);

    core_areset = 1'b0;
    step(2);

    // Round-robin over two IMCs, one track each.
    run_track("t1a");
    chk_wqe("t1a wqe", 0, 4'd2, 32'h0, 32'h1000, 1'b1);
    chk("t1a next qpn", {28'd0, cur_wr_QPN}, 32'd3);
    run_track("t1b");
    chk_wqe("t1b wqe", 1, 4'd3, 32'h0, 32'h1000, 1'b1);
    run_track("t1c");
    chk_wqe("t1c wqe", 2, 4'd2, 32'h0, 32'h1000, 1'b1);
    chk("t1 wqe count", 32'(wq.size()), 32'd3);
    chk("t1 done count", 32'(n_done), 32'd3);

    // Track split into three WQEs on QPN 3.
    track_bytes = 32'h28000;
    b = wq.size();
    run_track("t2");
    chk_wqe("t2 w0", b,     4'd3, 32'h0,     32'h10000, 1'b0);
    chk_wqe("t2 w1", b + 1, 4'd3, 32'h10000, 32'h10000, 1'b0);
    chk_wqe("t2 w2", b + 2, 4'd3, 32'h20000, 32'h8000,  1'b1);
    chk("t2 wqe count", 32'(wq.size() - b), 32'd3);

    // Three tracks per QP with a single IMC: offsets step then wrap.
    IMC_NUM           = 4'd1;
    track_num_per_IMC = 4'd3;
    track_bytes       = 32'h1000;
    b = wq.size();
    for (int i = 0; i < 6; i++) begin
      run_track("t3");
      chk_wqe("t3 wqe", b + i, 4'd2, 32'((i % 3) * 32'h1000), 32'h1000, 1'b1);
    end

    // Outstanding cap with completions withheld.
    track_num_per_IMC = 4'd1;
    track_bytes       = 32'h60000;
    b  = wq.size();
    d0 = n_done;
    RDMA_write_en = 1'b1;
    step(1);
    RDMA_write_en = 1'b0;
    step(10);
    chk("t4 capped hs", 32'(wq.size() - b), 32'd4);
    chk("t4 capped valid", {31'd0, wqe_req_valid}, 32'd0);
    chk("t4 capped cnt", {28'd0, outstanding_cnt}, 32'd4);
    cq_done_valid = 1'b1;
    step(1);
    cq_done_valid = 1'b0;
    step(6);
    chk("t4 one more hs", 32'(wq.size() - b), 32'd5);
    chk("t4 recapped valid", {31'd0, wqe_req_valid}, 32'd0);
    chk("t4 recapped cnt", {28'd0, outstanding_cnt}, 32'd4);
    cq_done_valid = 1'b1;
    step(1);
    chk("t4 reopen valid", {31'd0, wqe_req_valid}, 32'd1);
    chk("t4 reopen cnt", {28'd0, outstanding_cnt}, 32'd3);
    step(1);
    cq_done_valid = 1'b0;
    chk("t4 hs+cpl cnt", {28'd0, outstanding_cnt}, 32'd3);
    chk("t4 total hs", 32'(wq.size() - b), 32'd6);
    chk_wqe("t4 last wqe", b + 5, 4'd2, 32'h50000, 32'h10000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cq_done_valid = 1'b1;
      step(1);
      cq_done_valid = 1'b0;
      step(1);
    end
    for (int t = 0; t < 10 && n_done == d0; t++)
      step(1);
    chk("t4 done", 32'(n_done - d0), 32'd1);
    chk("t4 no err", {31'd0, sched_err}, 32'd0);

    // Unregistered MR for QPN 2.
    host_MR_valid = 7'h7E;
    track_bytes   = 32'h1000;
    b  = wq.size();
    d0 = n_done;
    RDMA_write_en = 1'b1;
    step(1);
    RDMA_write_en = 1'b0;
    step(5);
    chk("t5 err", {31'd0, sched_err}, 32'd1);
    chk("t5 busy", {31'd0, sched_busy}, 32'd0);
    chk("t5 valid", {31'd0, wqe_req_valid}, 32'd0);
    chk("t5 no wqe", 32'(wq.size() - b), 32'd0);
    chk("t5 no done", 32'(n_done - d0), 32'd0);
    core_areset = 1'b1;
    #1;
    chk("t5 async clear err", {31'd0, sched_err}, 32'd0);
    step(2);
    core_areset   = 1'b0;
    host_MR_valid = 7'h7F;
    step(1);
    chk("t5 qpn after rst", {28'd0, cur_wr_QPN}, 32'd2);

    // Completion with error status mid-track on QPN 3.
    IMC_NUM     = 4'd2;
    track_bytes = 32'h1000;
    run_track("t6a");
    chk("t6 qpn", {28'd0, cur_wr_QPN}, 32'd3);
    track_bytes = 32'h30000;
    b  = wq.size();
    d0 = n_done;
    RDMA_write_en = 1'b1;
    step(1);
    RDMA_write_en = 1'b0;
    step(8);
    chk("t6 issued", 32'(wq.size() - b), 32'd3);
    cq_done_valid = 1'b1;
    cq_error      = 1'b1;
    step(1);
    cq_done_valid = 1'b0;
    cq_error      = 1'b0;
    chk("t6 err", {31'd0, sched_err}, 32'd1);
    chk("t6 busy", {31'd0, sched_busy}, 32'd0);
    step(3);
    chk("t6 no done", 32'(n_done - d0), 32'd0);
    chk("t6 valid", {31'd0, wqe_req_valid}, 32'd0);
    core_areset = 1'b1;
    #1;
    chk("t6 rst qpn", {28'd0, cur_wr_QPN}, 32'd2);
    chk("t6 rst err", {31'd0, sched_err}, 32'd0);
    chk("t6 rst cnt", {28'd0, outstanding_cnt}, 32'd0);
    step(2);
    core_areset = 1'b0;
    step(1);

    // Stray completion while idle.
    cq_done_valid = 1'b1;
    step(1);
    cq_done_valid = 1'b0;
    chk("t7 underflow err", {31'd0, sched_err}, 32'd1);
    chk("t7 busy", {31'd0, sched_busy}, 32'd0);
    core_areset = 1'b1;
    step(2);
    core_areset = 1'b0;
    step(1);

    // Empty track completes without any WQE.
    track_bytes = 32'h0;
    b  = wq.size();
    d0 = n_done;
    RDMA_write_en = 1'b1;
    step(1);
    RDMA_write_en = 1'b0;
    chk("t8 done early", {31'd0, RDMA_track_done}, 32'd0);
    step(1);
    chk("t8 done pulse", {31'd0, RDMA_track_done}, 32'd1);
    chk("t8 busy", {31'd0, sched_busy}, 32'd1);
    step(1);
    chk("t8 done cleared", {31'd0, RDMA_track_done}, 32'd0);
    chk("t8 no wqe", 32'(wq.size() - b), 32'd0);
    chk("t8 done count", 32'(n_done - d0), 32'd1);
    chk("t8 no err", {31'd0, sched_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
